// File: rtl/mxv_pkg.sv
// Shared types for the MxV lane result path: lane count, lane index type and
// the result sequencer state encoding.
package mxv_pkg;

    localparam int LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_SEND = 1'b1
    } seq_state_t;

    // Next lane in round-robin order (wraps 3 -> 0 through the 2-bit type).
    function automatic lane_idx_t lane_inc(input lane_idx_t idx);
        return idx + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/result_sequencer_if.sv
// Lane-side and transmit-side signals of the result sequencer.
// Optional build macro RESULT_SEQ_TAG_EN adds the result_tag (source lane) signal.
interface result_sequencer_if #(
    parameter int Size = 8
);
    import mxv_pkg::*;

    logic [LANES*Size-1:0] lane_result;
    logic [LANES-1:0]      lane_valid;
    logic [LANES-1:0]      lane_full;
    logic                  send;
    logic                  tx_ready;
    logic [Size-1:0]       result_send;
    logic                  frame_done;
    logic                  overflow;
`ifdef RESULT_SEQ_TAG_EN
    lane_idx_t             result_tag;
`endif

    // Lanes and transmitter side.
    modport master (
        output lane_result, lane_valid, tx_ready,
`ifdef RESULT_SEQ_TAG_EN
        input  result_tag,
`endif
        input  lane_full, send, result_send, frame_done, overflow
    );

    // Sequencer side.
    modport slave (
        input  lane_result, lane_valid, tx_ready,
`ifdef RESULT_SEQ_TAG_EN
        output result_tag,
`endif
        output lane_full, send, result_send, frame_done, overflow
    );

endinterface

// File: rtl/result_sequencer_arbiter.sv
// Combinational 4-way round-robin arbiter: grants the first requesting lane
// found when searching ptr, ptr+1, ... mod 4. Shared by the lane schedulers.
module rr_arbiter4
    import mxv_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  lane_idx_t        ptr,
    output lane_idx_t        grant,
    output logic             any
);

    lane_idx_t cand;

    // Walk the search order from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        cand  = '0;
        any   = |req;
        for (int k = LANES - 1; k >= 0; k--) begin
            cand = ptr + lane_idx_t'(k);
            if (req[cand]) begin
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/result_sequencer.sv
// Result sequencer: one holding slot per MxV lane, round-robin serialisation
// onto a single valid/ready result stream, per-vector transfer counting.
// Optional build macro RESULT_SEQ_TAG_EN drives result_tag with the granted lane.
//
// state    | meaning
// SEQ_IDLE | no result offered; pick the next full slot if any
// SEQ_SEND | result offered on result_send, waiting for tx_ready
module result_sequencer
    import mxv_pkg::*;
#(
    parameter int Size     = 8,
    parameter int FrameLen = 4
) (
    input  logic              clk,
    input  logic              reset,
    result_sequencer_if.slave bus
);

    seq_state_t        state;
    seq_state_t        state_next;
    lane_idx_t         rr_ptr;
    lane_idx_t         grant_q;
    lane_idx_t         arb_grant;
    logic              arb_any;
    logic [Size-1:0]   slot_data [LANES];
    logic [LANES-1:0]  slot_full;
    logic              send_q;
    logic [Size-1:0]   result_q;
    logic [7:0]        frame_cnt;
    logic              frame_done_q;
    logic              overflow_q;
    logic              load;
    logic              transfer;

    // send_q is only high in SEQ_SEND, so tx_ready is ignored while idle.
    assign transfer = send_q & bus.tx_ready;

    rr_arbiter4 u_arb (
        .req   (slot_full),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .any   (arb_any)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load marks the cycle a slot is granted onto the stream.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (arb_any) begin
                    load       = 1'b1;
                    state_next = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                if (transfer) begin
                    state_next = SEQ_IDLE;
                end
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    // Output stream register: load on grant, hold through backpressure, drop send on transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            send_q   <= 1'b0;
            result_q <= '0;
            grant_q  <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            send_q   <= 1'b1;
            result_q <= slot_data[arb_grant];
            grant_q  <= arb_grant;
        end else if (transfer) begin
            send_q   <= 1'b0;
            rr_ptr   <= lane_inc(grant_q);
        end
    end

    // Holding slots: a strobe into a full slot is dropped even if that slot drains this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_full  <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            if (|(bus.lane_valid & slot_full)) begin
                overflow_q <= 1'b1;
            end
            for (int i = 0; i < LANES; i++) begin
                if (bus.lane_valid[i] && !slot_full[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_data[i] <= bus.lane_result[i*Size +: Size];
                end else if (transfer && (grant_q == lane_idx_t'(i))) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // Transfer counter per output vector; frame_done is a one-cycle pulse after the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (transfer) begin
                if (frame_cnt == 8'(FrameLen - 1)) begin
                    frame_cnt    <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    frame_cnt    <= frame_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.lane_full   = slot_full;
    assign bus.send        = send_q;
    assign bus.result_send = result_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.overflow    = overflow_q;
`ifdef RESULT_SEQ_TAG_EN
    // grant_q is loaded together with result_send, so it doubles as the tag register.
    assign bus.result_tag  = grant_q;
`endif

endmodule

// File: tb/tb_result_sequencer.sv
// Scoreboard bench for result_sequencer: expected words are queued when lanes
// strobe and compared when the stream transfers; frame_done is checked against
// a transfer-count model every cycle.
module tb_result_sequencer;
    import mxv_pkg::*;

    localparam int SIZE      = 8;
    localparam int FRAME_LEN = 4;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   xfer_cnt  = 0;
    int   fd_count  = 0;
    int   model_cnt = 0;
    logic exp_fd    = 1'b0;

    always #5 clk = ~clk;

    result_sequencer_if #(.Size(SIZE)) bus ();

    result_sequencer #(.Size(SIZE), .FrameLen(FRAME_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] lane, input logic [7:0] data);
        exp_t e;
        e.lane = lane;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic strobe(input logic [3:0] mask, input logic [31:0] words);
        @(posedge clk); #1;
        bus.lane_result = words;
        bus.lane_valid  = mask;
        @(posedge clk); #1;
        bus.lane_valid  = '0;
    endtask

    task automatic wait_send(input int budget);
        int n = 0;
        while (!bus.send && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.send) check_val("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || bus.send) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) check_val("drain_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: score each transfer and check frame_done against the transfer-count model.
    always @(negedge clk) begin
        if (!reset) begin
            exp_fd    = 1'b0;
            model_cnt = 0;
        end else begin
            check_val("frame_done", bus.frame_done, exp_fd);
            if (bus.frame_done) fd_count++;
            exp_fd = 1'b0;
            if (bus.send && bus.tx_ready) begin
                xfer_cnt++;
                if (sb_q.size() == 0) begin
                    check_val("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("data", bus.result_send, e.data);
`ifdef RESULT_SEQ_TAG_EN
                    check_val("tag", bus.result_tag, e.lane);
`endif
                end
                model_cnt++;
                if (model_cnt == FRAME_LEN) begin
                    model_cnt = 0;
                    exp_fd    = 1'b1;
                end
            end
        end
    end

    initial begin
        int fd0;
        int xf0;
        bus.lane_result = '0;
        bus.lane_valid  = '0;
        bus.tx_ready    = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_send", bus.send, 0);
        check_val("rst_result", bus.result_send, 0);
        check_val("rst_full", bus.lane_full, 0);
        check_val("rst_frame_done", bus.frame_done, 0);
        check_val("rst_overflow", bus.overflow, 0);
`ifdef RESULT_SEQ_TAG_EN
        check_val("rst_tag", bus.result_tag, 0);
`endif
        reset = 1'b1;

        // Fairness: all lanes at once from rr_ptr 0, one frame completes.
        bus.tx_ready = 1'b1;
        fd0 = fd_count;
        push_exp(2'd0, 8'h11);
        push_exp(2'd1, 8'h22);
        push_exp(2'd2, 8'h33);
        push_exp(2'd3, 8'h44);
        strobe(4'hF, 32'h4433_2211);
        check_val("t2_full", bus.lane_full, 4'hF);
        wait_drain(40);
        repeat (2) @(posedge clk);
        #1;
        check_val("t2_fd_count", fd_count - fd0, 1);
        check_val("t2_empty", bus.lane_full, 0);

        // Single result on lane 2.
        push_exp(2'd2, 8'h5A);
        strobe(4'b0100, 32'h005A_0000);
        check_val("t1_full_set", bus.lane_full[2], 1);
        check_val("t1_send_early", bus.send, 0);
        @(posedge clk); #1;
        check_val("t1_send", bus.send, 1);
        check_val("t1_result", bus.result_send, 8'h5A);
`ifdef RESULT_SEQ_TAG_EN
        check_val("t1_tag", bus.result_tag, 2);
`endif
        @(posedge clk); #1;
        check_val("t1_full_clr", bus.lane_full[2], 0);
        check_val("t1_send_clr", bus.send, 0);

        // Backpressure: held stable for 5 cycles, accepted on first tx_ready.
        bus.tx_ready = 1'b0;
        push_exp(2'd0, 8'h7E);
        strobe(4'b0001, 32'h0000_007E);
        wait_send(10);
        for (int c = 0; c < 5; c++) begin
            check_val("t3_hold_send", bus.send, 1);
            check_val("t3_hold_data", bus.result_send, 8'h7E);
            @(posedge clk); #1;
        end
        bus.tx_ready = 1'b1;
        @(posedge clk); #1;
        check_val("t3_accepted", bus.send, 0);
        check_val("t3_queue", sb_q.size(), 0);

        // Overflow: second strobe into a full lane 1 slot is lost.
        bus.tx_ready = 1'b0;
        push_exp(2'd1, 8'h01);
        strobe(4'b0010, 32'h0000_0100);
        check_val("t4_no_ovf", bus.overflow, 0);
        strobe(4'b0010, 32'h0000_0200);
        check_val("t4_ovf", bus.overflow, 1);
        bus.tx_ready = 1'b1;
        wait_drain(20);
        repeat (3) @(posedge clk);
        #1;
        check_val("t4_ovf_sticky", bus.overflow, 1);
        check_val("t4_full", bus.lane_full, 0);

        // Reset while a result is stalled in SEND.
        bus.tx_ready = 1'b0;
        push_exp(2'd3, 8'hC3);
        strobe(4'b1000, 32'hC300_0000);
        wait_send(10);
        #2 reset = 1'b0;
        #1;
        check_val("t6_send", bus.send, 0);
        check_val("t6_result", bus.result_send, 0);
        check_val("t6_full", bus.lane_full, 0);
        check_val("t6_frame_done", bus.frame_done, 0);
        check_val("t6_overflow", bus.overflow, 0);
        sb_q.delete();
        xf0 = xfer_cnt;
        @(posedge clk); #1;
        bus.tx_ready = 1'b1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_val("t6_no_send", bus.send, 0);
        check_val("t6_no_xfer", xfer_cnt - xf0, 0);

        // Frame wrap: 9 transfers give frame_done after the 4th and 8th only.
        fd0 = fd_count;
        xf0 = xfer_cnt;
        for (int k = 0; k < 9; k++) begin
            logic [1:0] ln;
            logic [7:0] d;
            ln = 2'(k % 4);
            d  = 8'(8'h80 + k);
            push_exp(ln, d);
            strobe(4'(4'b0001 << ln), 32'(32'(d) << (8 * ln)));
            wait_drain(20);
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("t5_xfers", xfer_cnt - xf0, 9);
        check_val("t5_fd_count", fd_count - fd0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
